// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory read arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int unsigned PORT_FETCH = 0;
    localparam int unsigned PORT_DATA  = 1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: fetch/data requests and the shared response bus.
interface mem_arbiter_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDRESSLEN = 32
);
    logic [1:0]            req_valid;
    logic [ADDRESSLEN-1:0] req_addr0;
    logic [ADDRESSLEN-1:0] req_addr1;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [XLEN-1:0]       rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr0, req_addr1,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the prio port.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o
);
    always_comb begin
        grant_o = '0;
        unique case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = port_onehot(prio_i);
            default: grant_o = '0;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for fetch/data reads of a single-ported synchronous-read memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDRESSLEN = 32,
    parameter int unsigned TAM        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_arbiter_if.slave          bus,
    output logic [ADDRESSLEN-1:0] mem_address,
    input  logic [XLEN-1:0]       mem_out
);
    state_e                state_q;
    logic                  prio_q;
    logic                  port_q;
    logic                  fault_q;
    logic [ADDRESSLEN-1:0] addr_q;

    logic [1:0]            grant;
    logic                  accept_en;
    logic                  accepted;
    logic                  sel_port;
    logic [ADDRESSLEN-1:0] sel_addr;
    logic                  sel_fault;
    logic                  in_resp;

    rr_arbiter2 u_rr (
        .req_valid_i (bus.req_valid),
        .prio_i      (prio_q),
        .grant_o     (grant)
    );

    always_comb begin
        accept_en     = !reset && (state_q != ISSUE);
        bus.req_ready = accept_en ? grant : '0;
        accepted      = |bus.req_ready;
        sel_port      = grant[1];
        sel_addr      = sel_port ? bus.req_addr1 : bus.req_addr0;
        sel_fault     = (sel_addr[1:0] != 2'b00) ||
                        ({2'b00, sel_addr[ADDRESSLEN-1:2]} >= ADDRESSLEN'(TAM));
    end

    // addr_q is loaded at accept so the memory sees the address throughout ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            port_q  <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (accepted) begin
                        state_q <= ISSUE;
                        prio_q  <= ~sel_port;
                        port_q  <= sel_port;
                        fault_q <= sel_fault;
                        addr_q  <= sel_fault ? '0 : sel_addr;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE:   state_q <= RESP;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_resp       = !reset && (state_q == RESP);
        bus.rsp_valid = in_resp ? port_onehot(port_q) : '0;
        bus.rsp_err   = in_resp && fault_q;
        bus.rsp_data  = (in_resp && !fault_q) ? mem_out : '0;
        mem_address   = reset ? '0 : addr_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a synchronous-read memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AL   = 32;
    localparam int unsigned TAM  = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN), .ADDRESSLEN(AL)) bus ();
    logic [AL-1:0]   mem_address;
    logic [XLEN-1:0] mem_out;
    logic [XLEN-1:0] mem [0:TAM-1];

    mem_arbiter #(.XLEN(XLEN), .ADDRESSLEN(AL), .TAM(TAM)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .mem_address (mem_address),
        .mem_out     (mem_out)
    );

    always @(posedge clk) mem_out <= mem[mem_address[6:2]];

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic        grant_log[$];
    int unsigned acc_cyc_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic port, input logic [31:0] a, input int unsigned c);
        exp_t e;
        e.port = port;
        e.err  = (a[1:0] != 2'b00) || ((a >> 2) >= TAM);
        e.data = e.err ? 32'h0 : mem[a[6:2]];
        e.cyc  = c + 2;
        return e;
    endfunction

    exp_t       mon_e;
    logic [1:0] mon_acc;

    // Scoreboard: push on acceptance, pop on each response pulse.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_req_ready", {30'b0, bus.req_ready}, 32'h0);
            check("rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'h0);
            check("rst_rsp_data", bus.rsp_data, 32'h0);
            check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
            check("rst_mem_address", mem_address, 32'h0);
            sb.delete();
        end else begin
            if (bus.rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b want=00 (cycle %0d)", bus.rsp_valid, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_port", {30'b0, bus.rsp_valid}, {30'b0, port_onehot(mon_e.port)});
                    check("rsp_data", bus.rsp_data, mon_e.data);
                    check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, mon_e.err});
                    check("rsp_cycle", cyc, mon_e.cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_rsp: rsp_valid=00 want=%b (cycle %0d)", port_onehot(sb[0].port), cyc);
                void'(sb.pop_front());
            end
            mon_acc = bus.req_valid & bus.req_ready;
            if (mon_acc != 2'b00) begin
                check("ready_onehot", $countones(mon_acc), 32'd1);
                sb.push_back(model(mon_acc[1], mon_acc[1] ? bus.req_addr1 : bus.req_addr0, cyc));
                grant_log.push_back(mon_acc[1]);
                acc_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic single(input logic port, input logic [31:0] addr, input logic exp_err);
        logic got;
        got = 1'b0;
        bus.req_valid = port_onehot(port);
        if (port) bus.req_addr1 = addr;
        else      bus.req_addr0 = addr;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[port]) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL single_ready_timeout: addr=%h ready=%b want=%b", addr, bus.req_ready, port_onehot(port));
            bus.req_valid = 2'b00;
        end else begin
            check("single_ready", {30'b0, bus.req_ready}, {30'b0, port_onehot(port)});
            tick();
            bus.req_valid = 2'b00;
            @(negedge clk);
            @(negedge clk);
            check("single_rsp_valid", {30'b0, bus.rsp_valid}, {30'b0, port_onehot(port)});
            check("single_rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
            if (exp_err) check("single_err_data", bus.rsp_data, 32'h0);
        end
        drain();
    endtask

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        exp_err;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < TAM; i++) mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        mem[1] = 32'hDEAD_BEEF;
        bus.req_valid = 2'b00;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;

        vt[0] = '{1'b0, 32'h0000_0004, 1'b0};
        vt[1] = '{1'b1, 32'h0000_0006, 1'b1};
        vt[2] = '{1'b1, TAM * 4,       1'b1};
        vt[3] = '{1'b1, 32'h0000_007C, 1'b0};
        vt[4] = '{1'b0, 32'h0000_0000, 1'b0};
        vt[5] = '{1'b0, 32'hFFFF_FFFC, 1'b1};
        vt[6] = '{1'b1, 32'h0000_0001, 1'b1};
        vt[7] = '{1'b1, 32'h0000_0010, 1'b0};

        // First accept right after reset release, word 1 at byte 0x4.
        repeat (3) tick();
        reset = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_addr0 = 32'h4;
        @(negedge clk);
        check("t1_ready_cycle0", {30'b0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("t1_no_rsp_cycle1", {30'b0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        check("t1_rsp_valid", {30'b0, bus.rsp_valid}, 32'h1);
        check("t1_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
        check("t1_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
        drain();

        // Both ports continuously: grants alternate from port 0 every 2 cycles.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        grant_log.delete();
        acc_cyc_log.delete();
        bus.req_valid = 2'b11;
        bus.req_addr0 = 32'h0;
        bus.req_addr1 = 32'h8;
        repeat (8) tick();
        bus.req_valid = 2'b00;
        drain();
        check("rr_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("rr_grant", {31'b0, grant_log[i]}, i % 2);
            if (i > 0) check("rr_spacing", acc_cyc_log[i] - acc_cyc_log[i-1], 32'd2);
        end

        for (int i = 0; i < 8; i++) single(vt[i].port, vt[i].addr, vt[i].exp_err);

        // Reset during ISSUE drops the transaction.
        bus.req_valid = 2'b01;
        bus.req_addr0 = 32'h10;
        @(negedge clk);
        check("mid_rst_ready", {30'b0, bus.req_ready}, 32'h1);
        tick();
        reset = 1'b1;
        bus.req_valid = 2'b00;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_no_rsp", {30'b0, bus.rsp_valid}, 32'h0);
        single(1'b0, 32'h14, 1'b0);

        // Port 0 re-requests in its own response cycle.
        grant_log.delete();
        acc_cyc_log.delete();
        n = 0;
        bus.req_valid = 2'b01;
        bus.req_addr0 = 32'h8;
        for (int i = 0; i < 12 && n < 2; i++) begin
            @(negedge clk);
            if (bus.req_ready[0]) begin
                n++;
                if (n == 2) check("rereq_in_resp", {30'b0, bus.rsp_valid}, 32'h1);
            end
            tick();
        end
        bus.req_valid = 2'b00;
        drain();
        check("rereq_count", acc_cyc_log.size(), 32'd2);
        if (acc_cyc_log.size() >= 2) check("rereq_spacing", acc_cyc_log[1] - acc_cyc_log[0], 32'd2);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
